// File: rtl/bus_ctrl_pkg.sv
// Shared types and widths for the CPU bus controller: FSM states, access
// regions and the address decode helper used by bus_ctrl.
package bus_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    RGN_ROM,
    RGN_RAM,
    RGN_IO,
    RGN_INTA
  } region_t;

  // MREQ has priority over IORQ; IORQ together with M1 is an interrupt acknowledge.
  function automatic region_t decode_region(input logic mreq,
                                            input logic iorq,
                                            input logic m1,
                                            input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] rom_top);
    if (mreq)
      return (addr <= rom_top) ? RGN_ROM : RGN_RAM;
    else if (iorq && m1)
      return RGN_INTA;
    else
      return RGN_IO;
  endfunction

endpackage

// File: rtl/bus_ctrl_ws.sv
// Loadable 4-bit down-counter with zero flag, used to time the wait states
// that precede each device access.
module ws_counter (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_srst)
      r_count <= 4'd0;
    else if (i_load)
      r_count <= i_load_val;
    else if (i_dec && (r_count != 4'd0))
      r_count <= r_count - 4'd1;
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/bus_ctrl.sv
// CPU-side bus controller: decodes MREQ/IORQ into ROM, RAM, IO or interrupt
// acknowledge cycles, inserts wait states and returns registered read data.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ROM_TOP    = 16'h3FFF,
  parameter int                ROM_WS     = 1,
  parameter int                RAM_WS     = 0,
  parameter int                IO_WS      = 2,
  parameter int                IO_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] INTA_VEC   = 8'hFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_mreq,
  input  logic              i_iorq,
  input  logic              i_wr,
  input  logic              i_m1,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_do,
  output logic [DATA_W-1:0] o_di,
  output logic              o_wait,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  output logic              o_bus_we,
  output logic              o_cs_rom,
  output logic              o_cs_ram,
  output logic              o_cs_io,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic [DATA_W-1:0] i_io_rdata,
  input  logic              i_io_ready,
  output logic              o_bus_err
);

  localparam logic [7:0] IO_TO_LAST = 8'(IO_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_next;
  region_t           r_region;
  region_t           w_region;
  logic              r_wr;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_di;
  logic              r_bus_err;
  logic [7:0]        r_io_cnt;

  logic       w_req;
  logic [3:0] w_ws;
  logic       w_ws_load;
  logic       w_ws_dec;
  logic       w_ws_zero;
  logic       w_io_timeout;
  logic       w_access;

  assign w_req        = i_mreq | i_iorq;
  assign w_region     = decode_region(i_mreq, i_iorq, i_m1, i_addr, ROM_TOP);
  assign w_io_timeout = (r_io_cnt == IO_TO_LAST);
  assign w_access     = (r_state == ST_ACCESS);

  always_comb begin
    w_ws = 4'd0;
    case (w_region)
      RGN_ROM: w_ws = 4'(ROM_WS);
      RGN_RAM: w_ws = 4'(RAM_WS);
      RGN_IO:  w_ws = 4'(IO_WS);
      default: w_ws = 4'd0;
    endcase
  end

  // Loaded with WS-1 so that COUNT lasts exactly WS cycles ending on zero.
  ws_counter u_ws_counter (
    .i_clk      (i_clk),
    .i_srst     (i_reset),
    .i_load     (w_ws_load),
    .i_load_val (w_ws - 4'd1),
    .i_dec      (w_ws_dec),
    .o_zero     (w_ws_zero)
  );

  always_comb begin
    w_state_next = r_state;
    w_ws_load    = 1'b0;
    w_ws_dec     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_region == RGN_INTA) begin
            w_state_next = ST_DONE;
          end else if (w_ws != 4'd0) begin
            w_state_next = ST_COUNT;
            w_ws_load    = 1'b1;
          end else begin
            w_state_next = ST_ACCESS;
          end
        end
      end
      ST_COUNT: begin
        if (w_ws_zero)
          w_state_next = ST_ACCESS;
        else
          w_ws_dec = 1'b1;
      end
      ST_ACCESS: begin
        if (r_region != RGN_IO || i_io_ready || w_io_timeout)
          w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (!i_mreq && !i_iorq)
          w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_region    <= RGN_ROM;
      r_wr        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_di        <= '0;
      r_bus_err   <= 1'b0;
      r_io_cnt    <= 8'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_req) begin
        r_bus_addr  <= i_addr;
        r_bus_wdata <= i_do;
        r_wr        <= i_wr;
        r_region    <= w_region;
        if (w_region == RGN_INTA)
          r_di <= INTA_VEC;
      end
      if (w_access && r_region == RGN_IO && !i_io_ready)
        r_io_cnt <= r_io_cnt + 8'd1;
      else
        r_io_cnt <= 8'd0;
      if (w_access) begin
        case (r_region)
          RGN_ROM, RGN_RAM: begin
            if (!r_wr)
              r_di <= i_mem_rdata;
          end
          RGN_IO: begin
            if (i_io_ready) begin
              if (!r_wr)
                r_di <= i_io_rdata;
            end else if (w_io_timeout) begin
              if (!r_wr)
                r_di <= 8'hFF;
              r_bus_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ROM writes complete with normal timing but never reach the device.
  assign o_cs_rom    = w_access && (r_region == RGN_ROM) && !r_wr;
  assign o_cs_ram    = w_access && (r_region == RGN_RAM);
  assign o_cs_io     = w_access && (r_region == RGN_IO);
  assign o_bus_we    = r_wr && (o_cs_rom || o_cs_ram || o_cs_io);
  assign o_wait      = ((r_state == ST_IDLE) && w_req) || (r_state == ST_COUNT) || w_access;
  assign o_di        = r_di;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_wdata = r_bus_wdata;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_bus_ctrl.sv
// Scoreboarded bench for bus_ctrl: a driver issues CPU cycles and pushes the
// expected outcome; a monitor measures each completed cycle and compares.
module tb_bus_ctrl;
  import bus_ctrl_pkg::*;

  localparam logic [15:0] ROM_TOP  = 16'h3FFF;
  localparam int          ROM_WS   = 1;
  localparam int          RAM_WS   = 0;
  localparam int          IO_WS    = 2;
  localparam int          IO_TO    = 6;
  localparam logic [7:0]  INTA_VEC = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        mreq, iorq, wr, m1;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic [7:0]  di;
  logic        o_wait;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, cs_rom, cs_ram, cs_io;
  logic [7:0]  mem_rdata, io_rdata;
  logic        io_ready;
  logic        bus_err;

  bus_ctrl #(
    .ROM_TOP(ROM_TOP), .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .IO_WS(IO_WS),
    .IO_TIMEOUT(IO_TO), .INTA_VEC(INTA_VEC)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_mreq(mreq), .i_iorq(iorq), .i_wr(wr), .i_m1(m1),
    .i_addr(addr), .i_do(dout), .o_di(di), .o_wait(o_wait), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .o_bus_we(bus_we), .o_cs_rom(cs_rom), .o_cs_ram(cs_ram),
    .o_cs_io(cs_io), .i_mem_rdata(mem_rdata), .i_io_rdata(io_rdata),
    .i_io_ready(io_ready), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_c;
    int          rom_c;
    int          ram_c;
    int          io_c;
    int          we_c;
    logic [7:0]  di;
    logic        err;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         pushed = 0;
  int         popped = 0;
  logic [7:0] model_di = 8'h00;
  logic       model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: derives the whole cycle's observable outcome from the request.
  task automatic run_txn(input logic t_mreq, input logic t_iorq, input logic t_m1,
                         input logic t_wr, input logic [15:0] t_addr, input logic [7:0] t_do,
                         input logic [7:0] t_mrd, input logic [7:0] t_iord, input int rdy_at);
    exp_t e;
    int   iocnt;
    int   ws;
    bit   ok;
    e.wait_c = 0; e.rom_c = 0; e.ram_c = 0; e.io_c = 0; e.we_c = 0;
    e.addr = t_addr; e.wdata = t_do;
    if (t_mreq) begin
      bit is_rom = (t_addr <= ROM_TOP);
      ws = is_rom ? ROM_WS : RAM_WS;
      e.wait_c = ws + 2;
      if (is_rom) e.rom_c = t_wr ? 0 : 1;
      else        e.ram_c = 1;
      if (!is_rom && t_wr) e.we_c = 1;
      if (!t_wr) model_di = t_mrd;
    end else if (t_m1) begin
      e.wait_c = 1;
      model_di = INTA_VEC;
    end else begin
      ok = (rdy_at >= 1 && rdy_at <= IO_TO);
      e.io_c   = ok ? rdy_at : IO_TO;
      e.wait_c = 1 + IO_WS + e.io_c;
      e.we_c   = t_wr ? e.io_c : 0;
      if (!t_wr) model_di = ok ? t_iord : 8'hFF;
      if (!ok) model_err = 1'b1;
    end
    e.di  = model_di;
    e.err = model_err;
    sb.push_back(e);
    pushed++;

    mreq = t_mreq; iorq = t_iorq; m1 = t_m1; wr = t_wr; addr = t_addr; dout = t_do;
    io_ready = 1'b0;
    mem_rdata = 8'($urandom);
    io_rdata  = 8'($urandom);
    iocnt = 0;
    for (int cyc = 0; cyc <= 200; cyc++) begin
      @(posedge clk); #1;
      mem_rdata = (cs_rom || cs_ram) ? t_mrd : 8'($urandom);
      io_rdata  = cs_io ? t_iord : 8'($urandom);
      if (cs_io) begin
        iocnt++;
        io_ready = (rdy_at != 0) && (iocnt == rdy_at);
      end
      if (!o_wait) break;
      if (cyc == 200) begin
        vectors++; miscompares++;
        $display("FAIL txn_timeout: got wait=1 after 200 cycles expected wait=0");
      end
    end
    mreq = 1'b0; iorq = 1'b0; m1 = 1'b0; io_ready = 1'b0;
    @(posedge clk); #1;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: accumulates per-cycle strobes; a WAIT fall marks completion.
  initial begin : monitor
    int   w_c, r_c, m_c, i_c, we_c;
    bit   in_txn;
    exp_t e;
    w_c = 0; r_c = 0; m_c = 0; i_c = 0; we_c = 0; in_txn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_c = 0; r_c = 0; m_c = 0; i_c = 0; we_c = 0; in_txn = 0;
      end else if (o_wait) begin
        in_txn = 1;
        w_c++;
        r_c  += int'(cs_rom);
        m_c  += int'(cs_ram);
        i_c  += int'(cs_io);
        we_c += int'(bus_we);
      end else if (in_txn) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_txn: got completion expected none");
        end else begin
          e = sb.pop_front();
          popped++;
          $display("txn %0d: addr=%h wait=%0d rom=%0d ram=%0d io=%0d we=%0d di=%h err=%b",
                   popped, bus_addr, w_c, r_c, m_c, i_c, we_c, di, bus_err);
          check("wait_cycles", w_c, e.wait_c);
          check("cs_rom_cycles", r_c, e.rom_c);
          check("cs_ram_cycles", m_c, e.ram_c);
          check("cs_io_cycles", i_c, e.io_c);
          check("bus_we_cycles", we_c, e.we_c);
          check("di", di, e.di);
          check("bus_err", bus_err, e.err);
          check("bus_addr", bus_addr, e.addr);
          check("bus_wdata", bus_wdata, e.wdata);
        end
        w_c = 0; r_c = 0; m_c = 0; i_c = 0; we_c = 0; in_txn = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int          kind;
    logic [15:0] a;
    bit          seen;
    rst = 1'b1; mreq = 0; iorq = 0; wr = 0; m1 = 0; addr = 0; dout = 0;
    mem_rdata = 0; io_rdata = 0; io_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_di", di, 8'h00);
    check("rst_bus_addr", bus_addr, 16'h0000);
    check("rst_bus_wdata", bus_wdata, 8'h00);
    check("rst_strobes", {cs_rom, cs_ram, cs_io, bus_we}, 4'b0000);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_wait", o_wait, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1, 0, 0, 0, 16'h8000, 8'h00, 8'h5A, 8'h00, 0);  // RAM read
    run_txn(1, 0, 0, 1, 16'h0010, 8'h33, 8'h77, 8'h00, 0);  // ROM write
    run_txn(0, 1, 0, 0, 16'h0042, 8'h00, 8'h00, 8'hC3, 5);  // IO read, ready at 5
    run_txn(0, 1, 0, 1, 16'h0043, 8'h9C, 8'h00, 8'h00, 0);  // IO write, timeout
    run_txn(0, 1, 1, 0, 16'h0038, 8'h00, 8'h00, 8'h00, 0);  // INTA
    run_txn(1, 1, 1, 0, 16'h3FFF, 8'h00, 8'hA5, 8'h11, 0);  // MREQ wins, ROM edge
    run_txn(1, 1, 0, 0, 16'h4000, 8'h00, 8'h3C, 8'h22, 0);  // MREQ wins, RAM edge

    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = ROM_TOP;
        1: a = ROM_TOP + 16'd1;
        default: a = 16'($urandom);
      endcase
      case (kind)
        0, 1: run_txn(1, 1'($urandom), 1'($urandom), 1'($urandom), a, 8'($urandom),
                      8'($urandom), 8'($urandom), 0);
        2: run_txn(0, 1, 0, 1'($urandom), a, 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, IO_TO + 2)));
        default: run_txn(0, 1, 1, 1'($urandom), a, 8'($urandom), 8'($urandom),
                         8'($urandom), 0);
      endcase
    end

    // Abort an IO read mid-ACCESS with reset while IO_READY is offered.
    run_txn(1, 0, 0, 0, 16'h8001, 8'h00, 8'h5A, 8'h00, 0);
    mreq = 0; iorq = 1; m1 = 0; wr = 0; addr = 16'h0055; io_ready = 0;
    io_rdata = 8'hE7;
    seen = 0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(posedge clk); #1;
      seen = cs_io;
    end
    check("abort_reached_access", seen, 1'b1);
    rst = 1'b1; iorq = 0; io_ready = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_io", cs_io, 1'b0);
    check("abort_di", di, 8'h00);
    check("abort_wait", o_wait, 1'b0);
    check("abort_bus_err", bus_err, 1'b0);
    check("abort_bus_addr", bus_addr, 16'h0000);
    rst = 1'b0; io_ready = 1'b0;
    model_di = 8'h00; model_err = 1'b0;
    @(posedge clk); #1;

    run_txn(1, 0, 0, 1, 16'hC000, 8'h4B, 8'h00, 8'h00, 0);
    run_txn(0, 1, 0, 0, 16'h0001, 8'h00, 8'h00, 8'h69, 1);

    repeat (4) @(posedge clk);
    check("sb_drained", popped, pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
